// File: rtl/scpad_tile_beat_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scpad_tile_beat_gen_pkg
//  Description : Scratchpad geometry, tile/beat types and address helper
//                shared by the tile beat generator, its interface and its
//                lane calculator.
//  Revision    : 1.0 - initial release
// ============================================================================
package scpad_tile_beat_gen_pkg;

  localparam int NUM_COLS         = 32;
  localparam int NUM_ROWS         = 16384;
  localparam int MAX_TILE_SIZE    = 32;
  localparam int ELEM_BYTES       = 2;
  localparam int ELEM_SHIFT       = $clog2(ELEM_BYTES);
  localparam int ROW_BYTES        = NUM_COLS * ELEM_BYTES;
  localparam int ROW_SHIFT        = $clog2(ROW_BYTES);
  localparam int SCPAD_SIZE_BYTES = NUM_ROWS * ROW_BYTES;
  localparam int SCPAD_ADDR_WIDTH = $clog2(SCPAD_SIZE_BYTES);
  localparam int ROW_IDX_WIDTH    = $clog2(NUM_ROWS);
  localparam int COL_IDX_WIDTH    = $clog2(NUM_COLS);
  localparam int MAX_DIM_WIDTH    = $clog2(MAX_TILE_SIZE);
  localparam int SCPAD_ID_WIDTH   = 1;

  typedef enum logic {
    SRC_FE = 1'b0,
    SRC_BE = 1'b1
  } src_t;

  typedef logic [SCPAD_ADDR_WIDTH-1:0] scpad_addr_t;
  typedef logic [ROW_IDX_WIDTH-1:0]    row_idx_t;
  typedef logic [COL_IDX_WIDTH-1:0]    col_idx_t;
  typedef logic [MAX_DIM_WIDTH-1:0]    dim_t;
  typedef logic [SCPAD_ID_WIDTH-1:0]   scpad_id_t;

  typedef logic [NUM_COLS-1:0]                    mask_t;
  typedef logic [NUM_COLS-1:0][ROW_IDX_WIDTH-1:0] slot_mask_t;
  typedef logic [NUM_COLS-1:0][COL_IDX_WIDTH-1:0] shift_mask_t;

  typedef struct packed {
    scpad_addr_t addr;
    dim_t        rows;
    dim_t        cols;
    logic        colmajor;
    logic        write;
    scpad_id_t   scpad_id;
    src_t        src;
  } tile_desc_t;

  typedef struct packed {
    mask_t       mask;
    slot_mask_t  slot;
    shift_mask_t shift;
    dim_t        idx;
    logic        last;
    logic        write;
    scpad_id_t   scpad_id;
    src_t        src;
  } beat_t;

  typedef struct packed {
    row_idx_t row;
    col_idx_t col;
  } row_col_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } tbg_state_t;

  // Byte address -> (slot, element column); sub-element bits drop out.
  function automatic row_col_t addr_to_row_col(input scpad_addr_t addr);
    row_col_t rc;
    rc.row = row_idx_t'(addr >> ROW_SHIFT);
    rc.col = col_idx_t'(addr >> ELEM_SHIFT);
    return rc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scpad_tile_beat_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : scpad_tile_beat_gen_if
//  Description : Tile descriptor request channel and scratchpad beat channel.
//  Revision    : 1.0 - initial release
// ============================================================================
interface scpad_tile_beat_gen_if;
  import scpad_tile_beat_gen_pkg::*;

  logic        tile_valid;
  logic        tile_ready;
  scpad_addr_t tile_addr;
  dim_t        tile_rows;
  dim_t        tile_cols;
  logic        tile_colmajor;
  logic        tile_write;
  scpad_id_t   tile_scpad_id;
  src_t        tile_src;

  logic        beat_valid;
  logic        beat_ready;
  mask_t       beat_mask;
  slot_mask_t  beat_slot;
  shift_mask_t beat_shift;
  dim_t        beat_idx;
  logic        beat_last;
  logic        beat_write;
  scpad_id_t   beat_scpad_id;
  src_t        beat_src;

  modport master (
    output tile_valid, tile_addr, tile_rows, tile_cols, tile_colmajor,
           tile_write, tile_scpad_id, tile_src, beat_ready,
    input  tile_ready, beat_valid, beat_mask, beat_slot, beat_shift,
           beat_idx, beat_last, beat_write, beat_scpad_id, beat_src
  );

  modport slave (
    input  tile_valid, tile_addr, tile_rows, tile_cols, tile_colmajor,
           tile_write, tile_scpad_id, tile_src, beat_ready,
    output tile_ready, beat_valid, beat_mask, beat_slot, beat_shift,
           beat_idx, beat_last, beat_write, beat_scpad_id, beat_src
  );

endinterface
`default_nettype wire

// File: rtl/scpad_tile_beat_gen_lane_calc.sv
`default_nettype none
// ============================================================================
//  Module      : scpad_skew_lane_calc
//  Description : Per-lane mask/slot/column for one beat of a skewed tile.
//  Revision    : 1.0 - initial release
// ============================================================================
module scpad_skew_lane_calc
  import scpad_tile_beat_gen_pkg::*;
(
  input  row_idx_t    i_base_row,
  input  col_idx_t    i_base_col,
  input  dim_t        i_k,
  input  logic        i_colmajor,
  input  dim_t        i_rows,
  input  dim_t        i_cols,
  output mask_t       o_mask,
  output slot_mask_t  o_slot,
  output shift_mask_t o_shift
);

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_lane
    localparam dim_t c_LANE = dim_t'(i);

    logic     w_active;
    row_idx_t w_slot;
    col_idx_t w_shift;

    // Lane is the tile column in row-major beats and the tile row in
    // column-major beats; the skewed column is (base_col + r + c) either way.
    assign w_active = i_colmajor ? (c_LANE <= i_rows) : (c_LANE <= i_cols);
    assign w_slot   = i_colmajor ? (i_base_row + row_idx_t'(c_LANE))
                                 : (i_base_row + row_idx_t'(i_k));
    assign w_shift  = i_base_col + col_idx_t'(c_LANE) + col_idx_t'(i_k);

    assign o_mask[i]  = w_active;
    assign o_slot[i]  = w_active ? w_slot  : '0;
    assign o_shift[i] = w_active ? w_shift : '0;
  end

endmodule
`default_nettype wire

// File: rtl/scpad_tile_beat_gen.sv
`default_nettype none
// ============================================================================
//  Module      : scpad_tile_beat_gen
//  Description : Expands one tile descriptor into one skewed scratchpad beat
//                per cycle behind a registered valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module scpad_tile_beat_gen
  import scpad_tile_beat_gen_pkg::*;
(
  input  logic                         CLK,
  input  logic                         nRST,
  scpad_tile_beat_gen_if.slave         bus
);

  tbg_state_t  r_state;
  tbg_state_t  w_state_next;
  tile_desc_t  r_desc;
  tile_desc_t  w_tile_in;
  tile_desc_t  w_desc;
  dim_t        r_k;
  dim_t        w_k;
  dim_t        w_last_k;
  beat_t       r_beat;
  logic        r_beat_valid;
  logic        w_in_idle;
  logic        w_load;
  logic        w_last;
  row_col_t    w_base;
  mask_t       w_mask;
  slot_mask_t  w_slot;
  shift_mask_t w_shift;

  assign w_tile_in = '{addr:     bus.tile_addr,
                       rows:     bus.tile_rows,
                       cols:     bus.tile_cols,
                       colmajor: bus.tile_colmajor,
                       write:    bus.tile_write,
                       scpad_id: bus.tile_scpad_id,
                       src:      bus.tile_src};

  // Beat 0 is built straight from the incoming descriptor so it can load on
  // the accepting edge; later beats use the latched copy.
  assign w_in_idle = (r_state == S_IDLE);
  assign w_desc    = w_in_idle ? w_tile_in : r_desc;
  assign w_k       = w_in_idle ? '0 : r_k;
  assign w_base    = addr_to_row_col(w_desc.addr);
  assign w_last_k  = w_desc.colmajor ? w_desc.cols : w_desc.rows;
  assign w_last    = (w_k == w_last_k);

  scpad_skew_lane_calc u_lane_calc (
    .i_base_row (w_base.row),
    .i_base_col (w_base.col),
    .i_k        (w_k),
    .i_colmajor (w_desc.colmajor),
    .i_rows     (w_desc.rows),
    .i_cols     (w_desc.cols),
    .o_mask     (w_mask),
    .o_slot     (w_slot),
    .o_shift    (w_shift)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.tile_valid) begin
          w_load       = 1'b1;
          w_state_next = w_last ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!r_beat_valid || bus.beat_ready) begin
          w_load = 1'b1;
          if (w_last) begin
            w_state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (bus.beat_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_desc       <= '0;
      r_k          <= '0;
      r_beat       <= '0;
      r_beat_valid <= 1'b0;
    end else begin
      if (w_in_idle && bus.tile_valid) begin
        r_desc <= w_tile_in;
      end
      if (w_load) begin
        r_k          <= w_k + dim_t'(1);
        r_beat       <= '{mask:     w_mask,
                          slot:     w_slot,
                          shift:    w_shift,
                          idx:      w_k,
                          last:     w_last,
                          write:    w_desc.write,
                          scpad_id: w_desc.scpad_id,
                          src:      w_desc.src};
        r_beat_valid <= 1'b1;
      end else if (bus.beat_ready) begin
        r_beat_valid <= 1'b0;
      end
    end
  end

  assign bus.tile_ready    = w_in_idle;
  assign bus.beat_valid    = r_beat_valid;
  assign bus.beat_mask     = r_beat.mask;
  assign bus.beat_slot     = r_beat.slot;
  assign bus.beat_shift    = r_beat.shift;
  assign bus.beat_idx      = r_beat.idx;
  assign bus.beat_last     = r_beat.last;
  assign bus.beat_write    = r_beat.write;
  assign bus.beat_scpad_id = r_beat.scpad_id;
  assign bus.beat_src      = r_beat.src;

endmodule
`default_nettype wire

// File: tb/tb_scpad_tile_beat_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scpad_tile_beat_gen
//  Description : Scoreboard bench for the scratchpad tile beat generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scpad_tile_beat_gen;
  import scpad_tile_beat_gen_pkg::*;

  logic  clk = 1'b0;
  logic  nRST;
  int    n_vec = 0;
  int    n_err = 0;
  beat_t sb[$];
  beat_t e;
  beat_t m_exp;

  always #5 clk = ~clk;

  scpad_tile_beat_gen_if bus ();

  scpad_tile_beat_gen dut (
    .CLK  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [447:0] got, input logic [447:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic cmp_beat(input string tag, input beat_t x);
    chk({tag, "_mask"},  bus.beat_mask,     x.mask);
    chk({tag, "_slot"},  bus.beat_slot,     x.slot);
    chk({tag, "_shift"}, bus.beat_shift,    x.shift);
    chk({tag, "_idx"},   bus.beat_idx,      x.idx);
    chk({tag, "_last"},  bus.beat_last,     x.last);
    chk({tag, "_attr"},  {bus.beat_write, bus.beat_scpad_id, bus.beat_src},
                         {x.write, x.scpad_id, x.src});
  endtask

  function automatic beat_t model_beat(input scpad_addr_t addr, input int rows, input int cols,
                                       input bit cm, input bit wr, input scpad_id_t id,
                                       input src_t src, input int k);
    beat_t b;
    int br, bc, lim, kk;
    b   = '0;
    br  = int'(addr) / 64;
    bc  = (int'(addr) / 2) % 32;
    lim = cm ? rows : cols;
    kk  = cm ? cols + 1 : rows + 1;
    for (int i = 0; i < 32; i++) begin
      if (i <= lim) begin
        b.mask[i]  = 1'b1;
        b.slot[i]  = ROW_IDX_WIDTH'((br + (cm ? i : k)) % 16384);
        b.shift[i] = COL_IDX_WIDTH'((bc + i + k) % 32);
      end
    end
    b.idx      = dim_t'(k);
    b.last     = (k == kk - 1);
    b.write    = wr;
    b.scpad_id = id;
    b.src      = src;
    return b;
  endfunction

  // Monitor: every accepted beat is checked against the oldest expectation.
  always @(negedge clk) begin
    if (nRST && bus.beat_valid && bus.beat_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got idx %0d, expected no beat", bus.beat_idx);
      end else begin
        m_exp = sb.pop_front();
        cmp_beat("beat", m_exp);
      end
    end
  end

  task automatic send_tile(input scpad_addr_t addr, input int rows, input int cols, input bit cm,
                           input bit wr, input scpad_id_t id, input src_t src, input bit use_model);
    int n;
    if (use_model) begin
      for (int k = 0; k < (cm ? cols + 1 : rows + 1); k++) begin
        sb.push_back(model_beat(addr, rows, cols, cm, wr, id, src, k));
      end
    end
    bus.tile_addr     = addr;
    bus.tile_rows     = dim_t'(rows);
    bus.tile_cols     = dim_t'(cols);
    bus.tile_colmajor = cm;
    bus.tile_write    = wr;
    bus.tile_scpad_id = id;
    bus.tile_src      = src;
    bus.tile_valid    = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tile_ready && n < 100);
    if (!bus.tile_ready) begin
      chk("tile_accept_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    bus.tile_valid    = 1'b0;
    bus.tile_addr     = '1;
    bus.tile_rows     = '1;
    bus.tile_cols     = '1;
    bus.tile_colmajor = ~cm;
    bus.tile_write    = ~wr;
    chk("first_beat_valid", bus.beat_valid, 1);
    chk("tile_ready_busy",  bus.tile_ready, 0);
  endtask

  task automatic wait_drain(input bit toggle);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.beat_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (toggle) begin
        bus.beat_ready = ~bus.beat_ready;
      end
    end
    bus.beat_ready = 1'b1;
    chk("drain_done", (sb.size() == 0 && !bus.beat_valid), 1);
    chk("tile_ready_idle", bus.tile_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    nRST           = 1'b0;
    bus.beat_ready = 1'b1;
    bus.tile_valid = 1'b0;
    bus.tile_addr  = '0;
    bus.tile_rows  = '0;
    bus.tile_cols  = '0;
    bus.tile_colmajor = 1'b0;
    bus.tile_write    = 1'b0;
    bus.tile_scpad_id = '0;
    bus.tile_src      = SRC_FE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_beat_valid", bus.beat_valid, 0);
    chk("rst_tile_ready", bus.tile_ready, 1);
    chk("rst_outputs", {bus.beat_mask, bus.beat_idx, bus.beat_last, bus.beat_write}, 0);
    chk("rst_slot",  bus.beat_slot, 0);
    chk("rst_shift", bus.beat_shift, 0);
    nRST = 1'b1;
    @(posedge clk);
    #1;

    // 1: 4x32 row-major at address 0, one beat per cycle
    send_tile(20'h0, 3, 31, 1'b0, 1'b0, 1'b0, SRC_FE, 1'b1);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("t1_beat_valid", bus.beat_valid, 1);
      chk("t1_beat_idx",   bus.beat_idx, k);
    end
    @(posedge clk);
    #1;
    chk("t1_end_valid", bus.beat_valid, 0);
    wait_drain(1'b0);

    // 2: row 1, column 5, single 1x4 beat
    e = '0;
    e.mask = 32'hF;
    for (int i = 0; i < 4; i++) begin
      e.slot[i]  = 14'd1;
      e.shift[i] = 5'(5 + i);
    end
    e.last = 1'b1; e.write = 1'b1; e.scpad_id = 1'b1; e.src = SRC_BE;
    sb.push_back(e);
    send_tile(20'h4A, 0, 3, 1'b0, 1'b1, 1'b1, SRC_BE, 1'b0);
    wait_drain(1'b0);

    // 3: last slot, slot index wraps to 0 on beat 1
    e = '0;
    e.mask = 32'h1; e.slot[0] = 14'd16383; e.shift[0] = 5'd0;
    e.write = 1'b1; e.src = SRC_BE;
    sb.push_back(e);
    e.slot[0] = 14'd0; e.shift[0] = 5'd1; e.idx = 5'd1; e.last = 1'b1;
    sb.push_back(e);
    send_tile(20'(16383 * 64), 1, 0, 1'b0, 1'b1, 1'b0, SRC_BE, 1'b0);
    wait_drain(1'b0);

    // 4: 3x2 column-major
    e = '0;
    e.mask = 32'h7;
    for (int r = 0; r < 3; r++) begin
      e.slot[r]  = 14'(r);
      e.shift[r] = 5'(r);
    end
    sb.push_back(e);
    for (int r = 0; r < 3; r++) e.shift[r] = 5'(r + 1);
    e.idx = 5'd1; e.last = 1'b1;
    sb.push_back(e);
    send_tile(20'h0, 2, 1, 1'b1, 1'b0, 1'b0, SRC_FE, 1'b0);
    wait_drain(1'b0);

    // 5: case 1 with beat 2 stalled for 5 cycles
    send_tile(20'h0, 3, 31, 1'b0, 1'b0, 1'b0, SRC_FE, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.beat_ready = 1'b0;
    e = model_beat(20'h0, 3, 31, 1'b0, 1'b0, 1'b0, SRC_FE, 2);
    for (int s = 0; s < 5; s++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", bus.beat_valid, 1);
      chk("stall_tile_ready", bus.tile_ready, 0);
      cmp_beat("stall", e);
    end
    bus.beat_ready = 1'b1;
    wait_drain(1'b0);

    // 6: reset while beat 1 is presented, then a fresh tile
    send_tile(20'h0, 3, 31, 1'b0, 1'b0, 1'b0, SRC_FE, 1'b1);
    @(posedge clk);
    #1;
    nRST = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_beat_valid", bus.beat_valid, 0);
    chk("midrst_tile_ready", bus.tile_ready, 1);
    sb.delete();
    nRST = 1'b1;
    send_tile(20'h4A, 0, 3, 1'b0, 1'b1, 1'b1, SRC_BE, 1'b1);
    wait_drain(1'b0);

    // 7: full 32x32 column-major, shift wrap from column 30, ready toggling
    send_tile(20'(100 * 64 + 30 * 2), 31, 31, 1'b1, 1'b0, 1'b1, SRC_FE, 1'b1);
    wait_drain(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
